song_sequencer: RTL and testbench



---
 rtl/song_pkg.sv | 20 ++
 rtl/dffr.sv | 21 ++
 rtl/dffre.sv | 24 ++
 rtl/song_sequencer.sv | 153 +++++++++++++++
 tb/tb_song_sequencer.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/song_pkg.sv
// Shared types and constants for the song sequencer: FSM states and song ROM word layout.
package song_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      WAIT_ROM = 3'd2,
      LOAD     = 3'd3,
      PLAYING  = 3'd4,
      DONE     = 3'd5
   } song_state_e;

   localparam int NOTE_MSB = 11;
   localparam int NOTE_LSB = 6;
   localparam int DUR_MSB  = 5;
   localparam int DUR_LSB  = 0;

   localparam logic [5:0] END_DURATION = 6'd0;

endpackage

// File: rtl/dffr.sv
// Generic D flop with synchronous active-high reset to a parameterised value.
module dffr #(
   parameter int             W       = 1,
   parameter logic [W-1:0]   RST_VAL = {W{1'b0}}
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // state register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= RST_VAL;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/dffre.sv
// Generic D flop with load enable and synchronous active-high reset to a parameterised value.
module dffre #(
   parameter int             W       = 1,
   parameter logic [W-1:0]   RST_VAL = {W{1'b0}}
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // enabled register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= RST_VAL;
      end else if (en) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/song_sequencer.sv
// Steps the note player through one song of the song ROM, one {note, duration} word at a time.
// Optional SONG_SEQUENCER_LOOP_EN: restart the song at index 0 instead of stopping in DONE.
module song_sequencer
   import song_pkg::*;
#(
   parameter int NOTE_IDX_W = 5,
   parameter int SONG_W     = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         play,
   input  logic [SONG_W-1:0]            song,
   input  logic                         note_done,
   output logic [SONG_W+NOTE_IDX_W-1:0] rom_addr,
   input  logic [11:0]                  rom_data,
   output logic [5:0]                   note_to_load,
   output logic [5:0]                   duration_to_load,
   output logic                         load_new_note,
   output logic                         song_done,
   output logic [NOTE_IDX_W-1:0]        note_index
);

   localparam logic [NOTE_IDX_W-1:0] IDX_ZERO = {NOTE_IDX_W{1'b0}};
   localparam logic [NOTE_IDX_W-1:0] IDX_ONE  = {{(NOTE_IDX_W-1){1'b0}}, 1'b1};
   localparam logic [NOTE_IDX_W-1:0] IDX_LAST = {NOTE_IDX_W{1'b1}};

   logic [2:0]            state_bits_r;
   song_state_e           state_s;
   song_state_e           state_next_s;
   logic [NOTE_IDX_W-1:0] idx_r;
   logic [NOTE_IDX_W-1:0] idx_next_s;
   logic [SONG_W-1:0]     song_q_r;
   logic                  first_r;
   logic                  first_next_s;
   logic                  done_next_s;
   logic                  capture_s;
   logic [5:0]            rom_note_s;
   logic [5:0]            rom_dur_s;

   assign state_s    = song_state_e'(state_bits_r);
   assign rom_note_s = rom_data[NOTE_MSB:NOTE_LSB];
   assign rom_dur_s  = rom_data[DUR_MSB:DUR_LSB];

   // Tracking song every cycle gives song_q=song both at reset and one cycle after any change.
   always_ff @(posedge clk) begin
      song_q_r <= song;
   end

   // next-state, index, first-cycle and end-of-song decisions
   always_comb begin
      state_next_s = state_s;
      idx_next_s   = idx_r;
      first_next_s = first_r;
      done_next_s  = song_done;
      capture_s    = 1'b0;
      if (song != song_q_r) begin
         state_next_s = play ? FETCH : IDLE;
         idx_next_s   = IDX_ZERO;
         first_next_s = 1'b0;
         done_next_s  = 1'b0;
      end else if (!play) begin
         state_next_s = state_s;
      end else begin
`ifdef SONG_SEQUENCER_LOOP_EN
         done_next_s = 1'b0;
`endif
         case (state_s)
            IDLE:     state_next_s = FETCH;
            FETCH:    state_next_s = WAIT_ROM;
            WAIT_ROM: begin
               if (rom_dur_s == END_DURATION) begin
`ifdef SONG_SEQUENCER_LOOP_EN
                  idx_next_s   = IDX_ZERO;
                  state_next_s = FETCH;
                  done_next_s  = 1'b1;
`else
                  state_next_s = DONE;
                  done_next_s  = 1'b1;
`endif
               end else begin
                  capture_s    = 1'b1;
                  state_next_s = LOAD;
               end
            end
            LOAD: begin
               state_next_s = PLAYING;
               first_next_s = 1'b1;
            end
            PLAYING: begin
               // done is still high from the previous note in the first PLAYING cycle
               if (first_r) begin
                  first_next_s = 1'b0;
               end else if (note_done) begin
                  if (idx_r == IDX_LAST) begin
`ifdef SONG_SEQUENCER_LOOP_EN
                     idx_next_s   = IDX_ZERO;
                     state_next_s = FETCH;
                     done_next_s  = 1'b1;
`else
                     state_next_s = DONE;
                     done_next_s  = 1'b1;
`endif
                  end else begin
                     idx_next_s   = idx_r + IDX_ONE;
                     state_next_s = FETCH;
                  end
               end else begin
                  state_next_s = PLAYING;
               end
            end
            DONE: begin
               state_next_s = DONE;
               done_next_s  = 1'b1;
            end
            default: begin
               state_next_s = IDLE;
               idx_next_s   = IDX_ZERO;
               first_next_s = 1'b0;
            end
         endcase
      end
   end

   dffr #(.W(3), .RST_VAL(IDLE)) u_state (
      .clk(clk), .reset(reset), .d(state_next_s), .q(state_bits_r)
   );

   dffr #(.W(NOTE_IDX_W), .RST_VAL(IDX_ZERO)) u_idx (
      .clk(clk), .reset(reset), .d(idx_next_s), .q(idx_r)
   );

   dffr #(.W(1), .RST_VAL(1'b0)) u_first (
      .clk(clk), .reset(reset), .d(first_next_s), .q(first_r)
   );

   dffr #(.W(1), .RST_VAL(1'b0)) u_done (
      .clk(clk), .reset(reset), .d(done_next_s), .q(song_done)
   );

   dffre #(.W(6), .RST_VAL(6'd0)) u_note (
      .clk(clk), .reset(reset), .en(capture_s), .d(rom_note_s), .q(note_to_load)
   );

   dffre #(.W(6), .RST_VAL(6'd0)) u_dur (
      .clk(clk), .reset(reset), .en(capture_s), .d(rom_dur_s), .q(duration_to_load)
   );

   // Gating with play holds a paused LOAD pulse until play returns.
   assign load_new_note = (state_s == LOAD) && play;
   assign rom_addr      = {song_q_r, idx_r};
   assign note_index    = idx_r;

endmodule

// File: tb/tb_song_sequencer.sv
// Randomized bench for song_sequencer: counts play-high cycles between events to predict loads and end of song.
module tb_song_sequencer;

   localparam int PH_WAIT = 0;
   localparam int PH_PLAY = 1;
   localparam int PH_END  = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        play;
   logic [1:0]  song;
   logic        note_done;
   logic [6:0]  rom_addr;
   logic [11:0] rom_data;
   logic [5:0]  note_to_load;
   logic [5:0]  duration_to_load;
   logic        load_new_note;
   logic        song_done;
   logic [4:0]  note_index;

   logic [11:0] rom [0:127];

   int tests = 0;
   int fails = 0;

   int         m_phase;
   int         m_cnt;
   int         m_idx;
   logic       m_seen;
   logic [1:0] m_song;

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   song_sequencer dut (
      .clk(clk),
      .reset(reset),
      .play(play),
      .song(song),
      .note_done(note_done),
      .rom_addr(rom_addr),
      .rom_data(rom_data),
      .note_to_load(note_to_load),
      .duration_to_load(duration_to_load),
      .load_new_note(load_new_note),
      .song_done(song_done),
      .note_index(note_index)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
      end
   endtask

   // terminator at a random index; indices 32..39 mean the song fills all 32 slots
   task automatic fill_song(input int s, input bit full);
      int t;
      logic [5:0] n;
      logic [5:0] d;
      t = full ? 32 : int'($urandom_range(0, 39));
      for (int j = 0; j < 32; j++) begin
         n = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
         d = (j == t) ? 6'd0 : 6'($urandom_range(1, 63));
         rom[s*32 + j] = {n, d};
      end
   endtask

   // Loads land on the 3rd play-high cycle after a note is accepted; a terminator is seen on the 2nd.
   task automatic cycle(input logic p, input logic nd, input logic [1:0] s);
      logic [11:0] w;
      logic        term;
      logic        exp_pulse;
      @(posedge clk);
      #1;
      play      = p;
      note_done = nd;
      song      = s;
      @(negedge clk);
      w         = rom[int'(m_song)*32 + m_idx];
      term      = (w[5:0] == 6'd0);
      exp_pulse = p && (m_phase == PH_WAIT) && !term && (m_cnt == 2);
      check_eq("load_pulse", 32'(load_new_note), 32'(exp_pulse));
      check_eq("song_done", 32'(song_done), 32'(m_phase == PH_END));
      check_eq("note_index", 32'(note_index), 32'(m_idx));
      check_eq("rom_addr", 32'(rom_addr), 32'(int'(m_song)*32 + m_idx));
      if (exp_pulse) begin
         check_eq("note_to_load", 32'(note_to_load), 32'(w[11:6]));
         check_eq("duration_to_load", 32'(duration_to_load), 32'(w[5:0]));
      end
      if (s != m_song) begin
         m_song  = s;
         m_idx   = 0;
         m_phase = PH_WAIT;
         m_cnt   = p ? 0 : -1;
         m_seen  = 1'b0;
      end else if (p) begin
         case (m_phase)
            PH_WAIT: begin
               if (term && m_cnt == 1) m_phase = PH_END;
               else if (m_cnt == 2) begin
                  m_phase = PH_PLAY;
                  m_seen  = 1'b0;
               end else m_cnt++;
            end
            PH_PLAY: begin
               if (!m_seen) m_seen = 1'b1;
               else if (nd) begin
                  if (m_idx == 31) m_phase = PH_END;
                  else begin
                     m_idx++;
                     m_phase = PH_WAIT;
                     m_cnt   = 0;
                  end
               end
            end
            default: ;
         endcase
      end
   endtask

   initial begin
      logic [1:0] ns;
      int         n;
      reset     = 1'b1;
      play      = 1'b0;
      note_done = 1'b0;
      song      = 2'd0;
      for (int s = 0; s < 4; s++) fill_song(s, 1'b0);
      rom[0] = {6'd20, 6'd4};
      rom[1] = {6'd33, 6'd7};
      rom[2] = {6'd0, 6'd0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_load", 32'(load_new_note), 32'd0);
      check_eq("rst_done", 32'(song_done), 32'd0);
      check_eq("rst_note", 32'(note_to_load), 32'd0);
      check_eq("rst_dur", 32'(duration_to_load), 32'd0);
      check_eq("rst_index", 32'(note_index), 32'd0);
      check_eq("rst_addr", 32'(rom_addr), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      m_song  = 2'd0;
      m_idx   = 0;
      m_phase = PH_WAIT;
      m_cnt   = -1;
      m_seen  = 1'b0;
      ns      = 2'd0;

      for (int trial = 0; trial < 12; trial++) begin
         if (trial > 0) begin
            ns = 2'((int'(m_song) + int'($urandom_range(1, 3))) % 4);
            fill_song(int'(ns), (trial == 3) || (trial == 8));
         end
         n = 0;
         while (m_phase != PH_END && n < 4000) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, ns);
            n++;
         end
         check_eq("trial_reaches_end", 32'(n < 4000), 32'd1);
         repeat ($urandom_range(20, 100)) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, ns);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
